// File: rtl/ax_level_ctrl_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : ax_level_ctrl_unit_if
// Brief    : CSR access port shared with the CSR unit (write + combinational read).
// Revision : 1.0 - initial release
// ============================================================================
interface ax_level_ctrl_unit_if;
    logic        csrWE;
    logic [11:0] csrNumber;
    logic [1:0]  csrCode;
    logic [31:0] csrWriteIn;
    logic [31:0] csrReadOut;

    modport master (
        output csrWE,
        output csrNumber,
        output csrCode,
        output csrWriteIn,
        input  csrReadOut
    );

    modport slave (
        input  csrWE,
        input  csrNumber,
        input  csrCode,
        input  csrWriteIn,
        output csrReadOut
    );
endinterface
`default_nettype wire

// File: rtl/ax_level_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : ax_level_ctrl_unit
// Brief    : Multi-channel approximation level/threshold control with
//            commit-driven level decay. Optional macro
//            AX_CTRL_GLOBAL_OVERRIDE_EN adds a forceExact/freeze register.
// Revision : 1.0 - initial release
// ============================================================================
module ax_level_ctrl_unit #(
    parameter int          NUM_CHANNELS   = 4,
    parameter int          AX_LEVEL_WIDTH = 3,
    parameter int          THRESH_WIDTH   = 32,
    parameter int          COMMIT_WIDTH   = 3,
    parameter logic [11:0] CSR_BASE       = 12'h7C0
) (
    input  wire logic                                   clk,
    input  wire logic                                   rst,
    ax_level_ctrl_unit_if.slave                         s_csr,
    input  wire logic [COMMIT_WIDTH-1:0]                commitNum,
    output logic [NUM_CHANNELS*AX_LEVEL_WIDTH-1:0]      axLevel,
    output logic [NUM_CHANNELS*THRESH_WIDTH-1:0]        axThreshold,
    output logic [NUM_CHANNELS-1:0]                     axActive,
    output logic [NUM_CHANNELS-1:0]                     decayPulse
);

    localparam int         c_NUM_REGS    = 4 * NUM_CHANNELS;
    localparam logic [1:0] c_MODE_STATIC = 2'd1;
    localparam logic [1:0] c_MODE_DECAY  = 2'd2;

    logic [11:0]                  w_off;
    logic                         w_above;
    logic                         w_hit_ch;
    logic [9:0]                   w_ch_sel;
    logic [1:0]                   w_k;
    logic                         w_wr;
    logic [31:0]                  w_rdata;
    logic [31:0]                  w_wval;
    logic [NUM_CHANNELS*32-1:0]   w_rd_flat;
    logic                         w_force;
    logic                         w_freeze;

    assign w_off    = s_csr.csrNumber - CSR_BASE;
    assign w_above  = (s_csr.csrNumber >= CSR_BASE);
    assign w_hit_ch = w_above && (w_off < 12'(c_NUM_REGS));
    assign w_ch_sel = w_off[11:2];
    assign w_k      = w_off[1:0];
    assign w_wr     = s_csr.csrWE && (s_csr.csrCode != 2'd3);

`ifdef AX_CTRL_GLOBAL_OVERRIDE_EN
    logic       w_hit_g;
    logic [1:0] r_global;

    assign w_hit_g  = w_above && (w_off == 12'(c_NUM_REGS));
    assign w_force  = r_global[0];
    assign w_freeze = r_global[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_global <= 2'b00;
        end else if (w_wr && w_hit_g) begin
            r_global <= w_wval[1:0];
        end
    end
`else
    assign w_force  = 1'b0;
    assign w_freeze = 1'b0;
`endif

    // Old value for set/clear is the addressed register as read back.
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            w_rdata = w_rdata | w_rd_flat[i*32 +: 32];
        end
`ifdef AX_CTRL_GLOBAL_OVERRIDE_EN
        if (w_hit_g) begin
            w_rdata = {30'd0, r_global};
        end
`endif
    end

    always_comb begin
        w_wval = s_csr.csrWriteIn;
        case (s_csr.csrCode)
            2'd1:    w_wval = w_rdata | s_csr.csrWriteIn;
            2'd2:    w_wval = w_rdata & ~s_csr.csrWriteIn;
            default: w_wval = s_csr.csrWriteIn;
        endcase
    end

    assign s_csr.csrReadOut = w_rdata;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        logic [AX_LEVEL_WIDTH-1:0] r_level;
        logic [THRESH_WIDTH-1:0]   r_thresh;
        logic [1:0]                r_mode;
        logic [THRESH_WIDTH-1:0]   r_cnt;
        logic                      r_pulse;
        logic                      w_sel;
        logic                      w_wr_lvl;
        logic                      w_wr_thr;
        logic                      w_wr_mode;
        logic                      w_on;
        logic                      w_decay_en;
        logic [THRESH_WIDTH:0]     w_sum;
        logic [31:0]               w_rd;

        assign w_sel      = w_hit_ch && (w_ch_sel == 10'(i));
        assign w_wr_lvl   = w_wr && w_sel && (w_k == 2'd0);
        assign w_wr_thr   = w_wr && w_sel && (w_k == 2'd1);
        assign w_wr_mode  = w_wr && w_sel && (w_k == 2'd2);
        assign w_on       = (r_mode == c_MODE_STATIC) || (r_mode == c_MODE_DECAY);
        assign w_decay_en = (r_mode == c_MODE_DECAY) && (r_level != '0) &&
                            (r_thresh != '0) && !w_freeze;
        assign w_sum      = {1'b0, r_cnt} + (THRESH_WIDTH+1)'(commitNum);

        always_comb begin
            w_rd = '0;
            if (w_sel) begin
                case (w_k)
                    2'd0:    w_rd = 32'(r_level);
                    2'd1:    w_rd = 32'(r_thresh);
                    2'd2:    w_rd = {30'd0, r_mode};
                    default: w_rd = 32'(r_cnt);
                endcase
            end
        end

        assign w_rd_flat[i*32 +: 32] = w_rd;

        // A CSR write to this channel restarts its budget and wins over decay.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_level  <= '0;
                r_thresh <= '0;
                r_mode   <= 2'b00;
                r_cnt    <= '0;
                r_pulse  <= 1'b0;
            end else begin
                r_pulse <= 1'b0;
                if (w_wr_lvl || w_wr_thr || w_wr_mode) begin
                    if (w_wr_lvl) begin
                        r_level <= w_wval[AX_LEVEL_WIDTH-1:0];
                    end
                    if (w_wr_thr) begin
                        r_thresh <= THRESH_WIDTH'(w_wval);
                    end
                    if (w_wr_mode) begin
                        r_mode <= w_wval[1:0];
                    end
                    r_cnt <= '0;
                end else if (r_mode != c_MODE_DECAY) begin
                    r_cnt <= '0;
                end else if (w_decay_en) begin
                    if (w_sum >= {1'b0, r_thresh}) begin
                        r_level <= r_level - 1'b1;
                        r_cnt   <= '0;
                        r_pulse <= 1'b1;
                    end else begin
                        r_cnt <= w_sum[THRESH_WIDTH-1:0];
                    end
                end
            end
        end

        assign axLevel[i*AX_LEVEL_WIDTH +: AX_LEVEL_WIDTH] =
            (w_on && !w_force) ? r_level : '0;
        assign axActive[i]    = w_on && !w_force && (r_level != '0);
        assign axThreshold[i*THRESH_WIDTH +: THRESH_WIDTH] = r_thresh;
        assign decayPulse[i]  = r_pulse;
    end

endmodule
`default_nettype wire

// File: tb/tb_ax_level_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ax_level_ctrl_unit
// Brief    : Scoreboard bench for ax_level_ctrl_unit (optionally with
//            AX_CTRL_GLOBAL_OVERRIDE_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ax_level_ctrl_unit;

    localparam logic [11:0] c_BASE = 12'h7C0;
    localparam int          c_NCH  = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   r_commit;
    logic [11:0]  w_axLevel;
    logic [127:0] w_axThreshold;
    logic [3:0]   w_axActive;
    logic [3:0]   w_decayPulse;

    logic [63:0]  exp_q[$];
    logic [63:0]  e;
    logic [63:0]  got;
    logic [31:0]  rd;
    int           errors = 0;
    int           checks = 0;

    ax_level_ctrl_unit_if u_if ();

    ax_level_ctrl_unit u_dut (
        .clk         (clk),
        .rst         (rst),
        .s_csr       (u_if),
        .commitNum   (r_commit),
        .axLevel     (w_axLevel),
        .axThreshold (w_axThreshold),
        .axActive    (w_axActive),
        .decayPulse  (w_decayPulse)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] addr(input int ch, input int k);
        return c_BASE + 12'(4 * ch + k);
    endfunction

    task automatic csr_write(input logic [11:0] a, input logic [1:0] code, input logic [31:0] d);
        @(negedge clk);
        u_if.csrWE      = 1'b1;
        u_if.csrNumber  = a;
        u_if.csrCode    = code;
        u_if.csrWriteIn = d;
        @(negedge clk);
        u_if.csrWE   = 1'b0;
        u_if.csrCode = 2'd3;
    endtask

    task automatic csr_read(input logic [11:0] a, output logic [31:0] d);
        u_if.csrNumber = a;
        #1;
        d = u_if.csrReadOut;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        u_if.csrWE = 1'b0; u_if.csrCode = 2'd3; u_if.csrNumber = c_BASE; u_if.csrWriteIn = '0;
        r_commit = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a <= 4 * c_NCH; a++) begin
            exp_q.push_back(64'd0);
            csr_read(c_BASE + 12'(a), rd);
            got = 64'(rd); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL reset_rd addr=%h got=%h exp=%h", c_BASE + 12'(a), got, e); end
        end
        exp_q.push_back(64'd0);
        got = 64'({w_axLevel, w_axActive, w_decayPulse}); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL reset_outs got=%h exp=%h", got, e); end
    endtask

    task automatic test_static;
        csr_write(addr(1, 0), 2'd0, 32'd5);
        csr_write(addr(1, 2), 2'd0, 32'd1);
        exp_q.push_back({32'd5, 32'd1});
        got = {29'd0, w_axLevel[5:3], 31'd0, w_axActive[1]}; e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL static_out got=%h exp=%h", got, e); end
        r_commit = 3'd2;
        repeat (100) @(negedge clk);
        r_commit = 3'd0;
        exp_q.push_back({32'd5, 32'd0});
        csr_read(addr(1, 3), rd);
        got[31:0] = rd;
        csr_read(addr(1, 0), rd);
        got[63:32] = rd; e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL static_hold got=%h exp=%h", got, e); end
    endtask

    task automatic test_decay;
        int mlevel, mcnt, pulses;
        logic p;
        csr_write(addr(0, 0), 2'd0, 32'd3);
        csr_write(addr(0, 1), 2'd0, 32'd10);
        csr_write(addr(0, 2), 2'd0, 32'd2);
        mlevel = 3; mcnt = 0; pulses = 0;
        r_commit = 3'd4;
        for (int c = 0; c < 20; c++) begin
            p = 1'b0;
            if (mlevel != 0) begin
                if (mcnt + 4 >= 10) begin mlevel--; mcnt = 0; p = 1'b1; end
                else mcnt += 4;
            end
            exp_q.push_back({21'd0, 3'(mlevel), 32'(mcnt), 7'd0, p});
            @(negedge clk);
            csr_read(addr(0, 3), rd);
            if (w_decayPulse[0] === 1'b1) pulses++;
            got = {21'd0, w_axLevel[2:0], rd, 4'd0, w_decayPulse}; e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL decay_cyc%0d got=%h exp=%h", c, got, e); end
        end
        r_commit = 3'd0;
        exp_q.push_back(64'd3);
        got = 64'(pulses); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL decay_pulses got=%0d exp=%0d", got, e); end
    endtask

    task automatic test_simultaneous;
        csr_write(addr(2, 0), 2'd0, 32'd1);
        csr_write(addr(2, 1), 2'd0, 32'd10);
        csr_write(addr(2, 2), 2'd0, 32'd2);
        r_commit = 3'd4;
        repeat (2) @(negedge clk);
        exp_q.push_back(64'd8);
        csr_read(addr(2, 3), rd);
        got = 64'(rd); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL simul_pre_cnt got=%h exp=%h", got, e); end
        r_commit = 3'd3;
        u_if.csrWE = 1'b1; u_if.csrNumber = addr(2, 0); u_if.csrCode = 2'd1; u_if.csrWriteIn = 32'd4;
        @(negedge clk);
        u_if.csrWE = 1'b0; u_if.csrCode = 2'd3; r_commit = 3'd0;
        exp_q.push_back({21'd0, 3'd5, 32'd5, 4'd0, 4'd0});
        csr_read(addr(2, 0), rd);
        got = {21'd0, w_axLevel[8:6], rd, 4'd0, w_decayPulse}; e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL simul_level got=%h exp=%h", got, e); end
        exp_q.push_back(64'd0);
        csr_read(addr(2, 3), rd);
        got = 64'(rd); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL simul_cnt got=%h exp=%h", got, e); end
    endtask

    task automatic test_fields;
        csr_write(addr(3, 0), 2'd0, 32'hFF);
        exp_q.push_back(64'd7);
        csr_read(addr(3, 0), rd);
        got = 64'(rd); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL lvl_trunc got=%h exp=%h", got, e); end
        r_commit = 3'd2;
        @(negedge clk);
        r_commit = 3'd0;
        csr_write(addr(2, 3), 2'd0, 32'h33);
        exp_q.push_back(64'd2);
        csr_read(addr(2, 3), rd);
        got = 64'(rd); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL cnt_ro got=%h exp=%h", got, e); end
        exp_q.push_back(64'd0);
        csr_read(c_BASE + 12'(4 * c_NCH + 1), rd);
        got = 64'(rd); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL unmapped_rd got=%h exp=%h", got, e); end
        csr_write(addr(1, 1), 2'd0, 32'hDEADBEEF);
        exp_q.push_back({32'hDEADBEEF, 32'hDEADBEEF});
        csr_read(addr(1, 1), rd);
        got = {rd, w_axThreshold[63:32]}; e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL thr_wr got=%h exp=%h", got, e); end
        csr_write(addr(1, 1), 2'd2, 32'hFFFF0000);
        exp_q.push_back(64'h0000BEEF);
        csr_read(addr(1, 1), rd);
        got = 64'(rd); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL thr_clr got=%h exp=%h", got, e); end
        csr_write(addr(1, 2), 2'd0, 32'd3);
        exp_q.push_back({32'd3, 29'd0, 3'd0});
        csr_read(addr(1, 2), rd);
        got = {rd, 29'd0, w_axLevel[5:3]}; e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL mode3_off got=%h exp=%h", got, e); end
        csr_write(addr(1, 2), 2'd0, 32'd1);
    endtask

`ifdef AX_CTRL_GLOBAL_OVERRIDE_EN
    task automatic test_override;
        int pulses;
        csr_write(c_BASE + 12'(4 * c_NCH), 2'd0, 32'd1);
        exp_q.push_back({32'd5, 16'd0, 12'd0, 4'd0});
        csr_read(addr(1, 0), rd);
        got = {rd, 16'd0, w_axLevel, w_axActive}; e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL force_exact got=%h exp=%h", got, e); end
        csr_write(c_BASE + 12'(4 * c_NCH), 2'd2, 32'd1);
        exp_q.push_back(64'd5);
        got = 64'(w_axLevel[5:3]); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL force_clr got=%h exp=%h", got, e); end
        csr_write(c_BASE + 12'(4 * c_NCH), 2'd0, 32'd2);
        r_commit = 3'd3; pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (w_decayPulse !== 4'd0) pulses++;
        end
        exp_q.push_back({32'd2, 32'd0});
        csr_read(addr(2, 3), rd);
        got = {rd, 32'(pulses)}; e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL freeze_hold got=%h exp=%h", got, e); end
        csr_write(c_BASE + 12'(4 * c_NCH), 2'd2, 32'd2);
        @(negedge clk);
        r_commit = 3'd0;
        exp_q.push_back(64'd5);
        csr_read(addr(2, 3), rd);
        got = 64'(rd); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL freeze_resume got=%h exp=%h", got, e); end
    endtask
`else
    task automatic test_no_global;
        csr_write(c_BASE + 12'(4 * c_NCH), 2'd0, 32'd3);
        exp_q.push_back({32'd0, 32'd5});
        csr_read(c_BASE + 12'(4 * c_NCH), rd);
        got = {rd, 29'd0, w_axLevel[5:3]}; e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL no_global got=%h exp=%h", got, e); end
    endtask
`endif

    task automatic test_reset_mid;
        csr_write(addr(0, 1), 2'd0, 32'd1);
        csr_write(addr(0, 0), 2'd0, 32'd1);
        r_commit = 3'd1;
        @(negedge clk);
        exp_q.push_back(64'd1);
        got = 64'(w_decayPulse[0]); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL mid_pulse got=%h exp=%h", got, e); end
        #1 rst = 1'b1;
        #1;
        exp_q.push_back(64'd0);
        csr_read(addr(1, 0), rd);
        got = {w_axLevel, w_axActive, w_decayPulse, w_axThreshold[31:0] | w_axThreshold[63:32]} | 64'(rd);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL mid_reset got=%h exp=%h", got, e); end
        r_commit = 3'd0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_static();
        test_decay();
        test_simultaneous();
        test_fields();
`ifdef AX_CTRL_GLOBAL_OVERRIDE_EN
        test_override();
`else
        test_no_global();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
